// File: rtl/dram_burst_packer.sv
// rtl/dram_burst_packer.sv - pixel byte packer, word FIFO and 16-beat burst announcer (optional DROP_COUNT_EN)
module dram_burst_packer #(
    parameter int DEPTH_LOG2 = 6,
    parameter int BURST_LEN  = 16
) (
    input  logic                  ACLK,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [7:0]            pix_in,
    input  logic                  pix_valid,
    input  logic                  pix_last,
    output logic                  pix_ready,
    output logic [63:0]           dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  burst_valid,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow
`ifdef DROP_COUNT_EN
    ,
    output logic [31:0]           drop_count
`endif
);

    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int LVL_W  = DEPTH_LOG2 + 1;
    localparam int BEAT_W = $clog2(BURST_LEN);

    typedef enum logic {FILL, PAD} state_t;

    state_t                  state, state_nxt;
    logic [2:0]              byte_idx;
    logic [63:0]             shreg;
    logic [63:0]             mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
    logic [BEAT_W-1:0]       words_mod, words_mod_inc;
    logic [BEAT_W-1:0]       beat_cnt;
    logic                    outstanding;

    logic                    not_full, accept, pack_push, pad_push, push, pop, issue;
    logic [63:0]             pack_word, push_data;

    assign not_full      = level < LVL_W'(DEPTH);
    assign pix_ready     = (state == FILL) && not_full;
    assign accept        = pix_valid && pix_ready;
    // Bytes above byte_idx are still zero in shreg, so a short tail word is zero-filled for free.
    assign pack_word     = shreg | ({56'd0, pix_in} << {byte_idx, 3'b000});
    assign pack_push     = accept && ((byte_idx == 3'd7) || pix_last);
    assign pad_push      = (state == PAD) && not_full;
    assign push          = pack_push || pad_push;
    assign push_data     = pad_push ? 64'd0 : pack_word;
    assign words_mod_inc = words_mod + 1'b1;

    assign dout          = mem[rd_ptr];
    assign dout_valid    = outstanding && (level != '0);
    assign pop           = dout_valid && dout_ready;
    assign issue         = !outstanding && (level >= LVL_W'(BURST_LEN)) && !burst_valid;

    always_comb begin
        state_nxt = state;
        case (state)
            FILL: if (accept && pix_last && (words_mod_inc != '0)) state_nxt = PAD;
            PAD:  if (pad_push && (words_mod_inc == '0))           state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (rst || clear) begin
            state       <= FILL;
            byte_idx    <= '0;
            shreg       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            words_mod   <= '0;
            outstanding <= 1'b0;
            beat_cnt    <= '0;
            burst_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                if (pack_push) begin
                    byte_idx <= '0;
                    shreg    <= '0;
                end else begin
                    byte_idx <= byte_idx + 3'd1;
                    shreg    <= pack_word;
                end
            end
            if (push) begin
                wr_ptr    <= wr_ptr + 1'b1;
                words_mod <= words_mod_inc;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + LVL_W'(push) - LVL_W'(pop);

            burst_valid <= issue;
            if (issue) begin
                outstanding <= 1'b1;
                beat_cnt    <= '0;
            end else if (pop) begin
                beat_cnt <= beat_cnt + 1'b1;
                if (beat_cnt == BEAT_W'(BURST_LEN - 1)) outstanding <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (push && !rst && !clear) mem[wr_ptr] <= push_data;
    end

    // Sticky across clear so a dropped byte is never silently forgotten.
    always_ff @(posedge ACLK) begin
        if (rst)                          overflow <= 1'b0;
        else if (pix_valid && !pix_ready) overflow <= 1'b1;
    end

`ifdef DROP_COUNT_EN
    always_ff @(posedge ACLK) begin
        if (rst)                                                 drop_count <= '0;
        else if (pix_valid && !pix_ready && (drop_count != '1)) drop_count <= drop_count + 32'd1;
    end
`endif

endmodule
